// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_responder
// Description : Memory-side responder for the MEM-stage data path. It takes
//               one request per transaction. A write merges the strobed byte
//               lanes into word storage at the accept edge. A read returns
//               the full 32-bit word after LATENCY cycles, so that pipeline
//               stall logic has real wait states to deal with.
//
// Parameters  : ADDR_WIDTH  word-index bits; depth = 2**ADDR_WIDTH words
//                           (at most 29, so the range-check field exists)
//               LATENCY     cycles from acceptance to o_data_ok (1..15)
//
// Ports       : clk          system clock, rising edge
//               rst          synchronous active-high reset
//               i_req        request valid, sampled while o_addr_ok = 1
//               i_sel[3:0]   byte write strobes; 4'b0000 = read
//               i_addr[31:0] byte address; [1:0] ignored
//               i_wdata[31:0] lane-replicated write data
//               o_addr_ok    idle, a request can be accepted this cycle
//               o_data_ok    one-cycle completion pulse
//               o_rdata[31:0] read word, held until the next o_data_ok
//               o_resp_err   valid with o_data_ok; 1 = address out of range
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_addr_ok,
    output logic        o_data_ok,
    output logic [31:0] o_rdata,
    output logic        o_resp_err
);

    localparam int         c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_LAT_M1    = 4'(LATENCY - 1);
    // With a single cycle of latency the response is produced straight
    // from the accept edge and WAIT is never entered.
    localparam bit         c_SKIP_WAIT = (LATENCY == 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_write;
    logic        r_err;
    logic [31:0] r_hold;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_oor;
    logic                  w_accept;
    logic                  w_wr_en;
    logic [31:0]           w_rd_word;
    logic                  w_unused;

    assign w_idx    = i_addr[ADDR_WIDTH+1:2];
    // Any set bit above the word index puts the address outside the array.
    assign w_oor    = |(i_addr >> (ADDR_WIDTH + 2));
    // Reset wins over a coincident request: no acceptance and no write.
    assign w_accept = (r_state == S_IDLE) && i_req && !rst;
    assign w_wr_en  = w_accept && (|i_sel) && !w_oor;
    // The byte offset carries no meaning for word accesses.
    assign w_unused = ^i_addr[1:0];

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane, so that a strobed merge is a
    // plain per-lane write enable. Contents are never reset.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [0:c_DEPTH-1];

            always_ff @(posedge clk) begin
                if (w_wr_en && i_sel[gi]) begin
                    r_lane[w_idx] <= i_wdata[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_lane[w_idx];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transaction FSM with registered handshake outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= 32'd0;
            o_addr_ok  <= 1'b1;
            o_data_ok  <= 1'b0;
            o_rdata    <= 32'd0;
            o_resp_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    o_data_ok  <= 1'b0;
                    o_resp_err <= 1'b0;
                    if (i_req) begin
                        r_is_write <= |i_sel;
                        r_err      <= w_oor;
                        // The array value is sampled before this edge's
                        // write lands; a read never writes, so this is exact.
                        r_hold     <= w_oor ? 32'd0 : w_rd_word;
                        r_cnt      <= c_LAT_M1;
                        o_addr_ok  <= 1'b0;
                        if (c_SKIP_WAIT) begin
                            r_state    <= S_RESP;
                            o_data_ok  <= 1'b1;
                            o_resp_err <= w_oor;
                            if (i_sel == 4'b0000) begin
                                o_rdata <= w_oor ? 32'd0 : w_rd_word;
                            end
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state    <= S_RESP;
                        r_cnt      <= 4'd0;
                        o_data_ok  <= 1'b1;
                        o_resp_err <= r_err;
                        // A write leaves the previous read word in place.
                        if (!r_is_write) begin
                            o_rdata <= r_hold;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                S_RESP: begin
                    r_state    <= S_IDLE;
                    o_data_ok  <= 1'b0;
                    o_resp_err <= 1'b0;
                    o_addr_ok  <= 1'b1;
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= 4'd0;
                    o_addr_ok  <= 1'b1;
                    o_data_ok  <= 1'b0;
                    o_resp_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_responder
// Description : Directed bench for data_sram_responder. One instance runs
//               with LATENCY=2 and another with LATENCY=1 (back-to-back held
//               request). Expected values are worked out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

    logic        clk;
    logic        rst;

    logic        req2, req1;
    logic [3:0]  sel2, sel1;
    logic [31:0] addr2, addr1, wdata2, wdata1;
    logic        addr_ok2, addr_ok1, data_ok2, data_ok1, err2, err1;
    logic [31:0] rdata2, rdata1;

    int n_checks = 0;
    int n_errors = 0;

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req2),
        .i_sel      (sel2),
        .i_addr     (addr2),
        .i_wdata    (wdata2),
        .o_addr_ok  (addr_ok2),
        .o_data_ok  (data_ok2),
        .o_rdata    (rdata2),
        .o_resp_err (err2)
    );

    data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req1),
        .i_sel      (sel1),
        .i_addr     (addr1),
        .i_wdata    (wdata1),
        .o_addr_ok  (addr_ok1),
        .o_data_ok  (data_ok1),
        .o_rdata    (rdata1),
        .o_resp_err (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full LATENCY=2 transaction on u_dut2, checked cycle by cycle.
    task automatic txn2(input string tag, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        chk({tag, ".addr_ok_idle"}, {31'd0, addr_ok2}, 32'd1);
        req2 = 1'b1; sel2 = s; addr2 = a; wdata2 = wd;
        tick;                                    // accept edge
        req2 = 1'b0; sel2 = 4'hF; addr2 = 32'hFFFF_FFFF; wdata2 = 32'h0;
        chk({tag, ".wait_addr_ok"}, {31'd0, addr_ok2}, 32'd0);
        chk({tag, ".wait_data_ok"}, {31'd0, data_ok2}, 32'd0);
        chk({tag, ".wait_err"},     {31'd0, err2},     32'd0);
        tick;                                    // accept + 2
        chk({tag, ".resp_data_ok"}, {31'd0, data_ok2}, 32'd1);
        chk({tag, ".resp_addr_ok"}, {31'd0, addr_ok2}, 32'd0);
        chk({tag, ".resp_rdata"},   rdata2,            exp_rd);
        chk({tag, ".resp_err"},     {31'd0, err2},     {31'd0, exp_err});
        tick;                                    // back to idle
        chk({tag, ".post_data_ok"}, {31'd0, data_ok2}, 32'd0);
        chk({tag, ".post_addr_ok"}, {31'd0, addr_ok2}, 32'd1);
        chk({tag, ".post_err"},     {31'd0, err2},     32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req2 = 1'b0; sel2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
        req1 = 1'b0; sel1 = 4'h0; addr1 = 32'h0; wdata1 = 32'h0;

        // Reset state
        tick; tick;
        chk("rst.addr_ok",  {31'd0, addr_ok2}, 32'd1);
        chk("rst.data_ok",  {31'd0, data_ok2}, 32'd0);
        chk("rst.rdata",    rdata2,            32'd0);
        chk("rst.err",      {31'd0, err2},     32'd0);
        chk("rst1.addr_ok", {31'd0, addr_ok1}, 32'd1);
        rst = 1'b0;

        // 1: full-word store then load
        txn2("sw10", 4'b1111, 32'h10, 32'hDEAD_BEEF, 32'h0,         1'b0);
        txn2("lw10", 4'b0000, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);

        // 2: lane merge; writes leave rdata at the last read word
        txn2("sw20", 4'b1111, 32'h20, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0);
        txn2("sb20", 4'b0100, 32'h22, 32'hAAAA_AAAA, 32'hDEAD_BEEF, 1'b0);
        txn2("sh20", 4'b0011, 32'h20, 32'h5566_5566, 32'hDEAD_BEEF, 1'b0);
        txn2("lw20", 4'b0000, 32'h20, 32'h0,         32'h11AA_5566, 1'b0);

        // 4: out-of-range address aliases word 0 in its index bits
        txn2("sw00",  4'b1111, 32'h0,      32'h0BAD_C0DE, 32'h11AA_5566, 1'b0);
        txn2("swoor", 4'b1111, 32'h1000,   32'hFFFF_FFFF, 32'h11AA_5566, 1'b1);
        txn2("lwoor", 4'b0000, 32'h1000,   32'h0,         32'h0,         1'b1);
        txn2("lw00",  4'b0000, 32'h0,      32'h0,         32'h0BAD_C0DE, 1'b0);
        txn2("lwhi",  4'b0000, 32'h8000_0000, 32'h0,      32'h0,         1'b1);

        // 6: store with no strobes behaves as a read
        txn2("sw30",   4'b1111, 32'h30, 32'hCAFE_F00D, 32'h0,         1'b0);
        txn2("fault",  4'b0000, 32'h30, 32'h1234_5678, 32'hCAFE_F00D, 1'b0);
        txn2("lw30",   4'b0000, 32'h30, 32'h0,         32'hCAFE_F00D, 1'b0);

        // 5a: reset during WAIT drops the pending response
        req2 = 1'b1; sel2 = 4'b0000; addr2 = 32'h10;
        tick;                                    // accept
        req2 = 1'b0;
        chk("rstw.in_wait", {31'd0, addr_ok2}, 32'd0);
        rst = 1'b1;
        tick;                                    // reset edge where data_ok was due
        rst = 1'b0;
        chk("rstw.data_ok", {31'd0, data_ok2}, 32'd0);
        chk("rstw.addr_ok", {31'd0, addr_ok2}, 32'd1);
        chk("rstw.rdata",   rdata2,            32'd0);
        tick;
        chk("rstw.no_late", {31'd0, data_ok2}, 32'd0);
        chk("rstw.idle",    {31'd0, addr_ok2}, 32'd1);

        // 5b: reset coincident with a write request suppresses the write
        rst = 1'b1; req2 = 1'b1; sel2 = 4'b1111; addr2 = 32'h10; wdata2 = 32'h9999_9999;
        tick;
        rst = 1'b0; req2 = 1'b0;
        chk("rstq.addr_ok", {31'd0, addr_ok2}, 32'd1);
        tick;
        chk("rstq.no_acc",  {31'd0, addr_ok2}, 32'd1);
        txn2("lw10b", 4'b0000, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // 3: LATENCY=1 with request held high: one acceptance every 2 cycles
        req1 = 1'b1; sel1 = 4'b1111; addr1 = 32'h40; wdata1 = 32'h5A5A_5A5A;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("l1.pulse%0d.data_ok", k), {31'd0, data_ok1}, 32'd1);
            chk($sformatf("l1.pulse%0d.addr_ok", k), {31'd0, addr_ok1}, 32'd0);
            chk($sformatf("l1.pulse%0d.rdata", k),   rdata1,            32'd0);
            tick;
            chk($sformatf("l1.gap%0d.data_ok", k),   {31'd0, data_ok1}, 32'd0);
            chk($sformatf("l1.gap%0d.addr_ok", k),   {31'd0, addr_ok1}, 32'd1);
        end
        sel1 = 4'b0000;
        tick;
        req1 = 1'b0;
        chk("l1.rd.data_ok", {31'd0, data_ok1}, 32'd1);
        chk("l1.rd.rdata",   rdata1,            32'h5A5A_5A5A);
        chk("l1.rd.err",     {31'd0, err1},     32'd0);
        tick;
        chk("l1.end.data_ok", {31'd0, data_ok1}, 32'd0);
        chk("l1.end.addr_ok", {31'd0, addr_ok1}, 32'd1);
        tick;
        chk("l1.idle.data_ok", {31'd0, data_ok1}, 32'd0);
        chk("l1.idle.rdata",   rdata1,            32'h5A5A_5A5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
